switch_conditioner: RTL and testbench

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

---
 rtl/io_pkg.sv | 12 +
 rtl/debounce_bit.sv | 62 ++++++
 rtl/switch_conditioner.sv | 30 +++
 tb/tb_switch_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for board I/O conditioning
package io_pkg;

    // Default debounce window in clock cycles (1 ms at 50 MHz)
    localparam int DEBOUNCE_DEFAULT = 50000;

    // Width of a counter that must reach db-1 without wrapping
    function automatic int debounce_cnt_width(input int db);
        return $clog2(db) + 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - per-bit synchroniser, debounce counter and edge pulses
module debounce_bit
    import io_pkg::*;
#(
    parameter int DB = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CW = debounce_cnt_width(DB);
    localparam logic [CW-1:0] LAST = CW'(DB - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          commit;

    // A change is accepted only after DB consecutive mismatching samples
    assign mismatch = (sync2 != stable);
    assign commit   = mismatch && (cnt == LAST);
    assign dout     = stable;

    // Two-flop synchroniser for the raw asynchronous switch level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Debounce counter, accepted level and single-cycle edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= commit && sync2;
            fall <= commit && !sync2;
            if (!mismatch) begin
                cnt <= '0;
            end else if (commit) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - debounces and synchronises the board switch bus
module switch_conditioner
    import io_pkg::*;
#(
    parameter int n  = 10,
    parameter int DB = DEBOUNCE_DEFAULT
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [n-1:0] Switches,
    output logic [n-1:0] SwOut,
    output logic [n-1:0] SwRise,
    output logic [n-1:0] SwFall
);

    // One independent conditioner per switch bit
    for (genvar i = 0; i < n; i++) begin : gen_bit
        debounce_bit #(
            .DB(DB)
        ) u_bit (
            .clk (Clock),
            .rst (Reset),
            .din (Switches[i]),
            .dout(SwOut[i]),
            .rise(SwRise[i]),
            .fall(SwFall[i])
        );
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - scoreboard bench for switch_conditioner
module tb_switch_conditioner;

    localparam int N  = 10;
    localparam int DB = 4;
    localparam int LAT = DB + 1;

    logic         Clock;
    logic         Reset;
    logic [N-1:0] Switches;
    logic [N-1:0] SwOut;
    logic [N-1:0] SwRise;
    logic [N-1:0] SwFall;

    switch_conditioner #(.n(N), .DB(DB)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Switches(Switches),
        .SwOut   (SwOut),
        .SwRise  (SwRise),
        .SwFall  (SwFall)
    );

    logic [2:0] cnt_vals [N];
    for (genvar g = 0; g < N; g++) begin : gen_probe
        assign cnt_vals[g] = dut.gen_bit[g].u_bit.cnt;
    end

    typedef struct {
        int           cyc;
        logic [N-1:0] out;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } ev_t;

    ev_t          exp_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         done = 1'b0;
    logic [N-1:0] prev_out = '0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial forever @(posedge Clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [N-1:0] o, input logic [N-1:0] r,
                           input logic [N-1:0] f);
        ev_t e;
        e.cyc = c; e.out = o; e.rise = r; e.fall = f;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every output event against the scoreboard queue
    initial begin
        ev_t e;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                check("reset_swout", 32'(SwOut), 32'd0);
                check("reset_swrise", 32'(SwRise), 32'd0);
                check("reset_swfall", 32'(SwFall), 32'd0);
                prev_out = '0;
            end else if (SwOut != prev_out || SwRise != '0 || SwFall != '0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got out=%0h rise=%0h fall=%0h expected none (cycle %0d)",
                             SwOut, SwRise, SwFall, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_swout", 32'(SwOut), 32'(e.out));
                    check("event_swrise", 32'(SwRise), 32'(e.rise));
                    check("event_swfall", 32'(SwFall), 32'(e.fall));
                end
                prev_out = SwOut;
            end
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (cnt_vals[i] > 3'(DB - 1)) begin
                    n_fail++;
                    $display("FAIL counter_bound bit %0d: got %0d expected <= %0d", i, cnt_vals[i], DB - 1);
                end
            end
            n_checks++;
            if ((SwRise & SwFall) != '0) begin
                n_fail++;
                $display("FAIL rise_fall_overlap: got %0h expected 0", SwRise & SwFall);
            end
            if (done) begin
                check("pending_events", 32'(exp_q.size()), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
            if (cyc > 3000) begin
                $display("FAIL watchdog: got cycle %0d expected done before 3000", cyc);
                $fatal(1, "watchdog expired");
            end
        end
    end

    // Stimulus: directed scenarios, each pushing the events it expects
    initial begin
        int e;
        Reset    = 1'b1;
        Switches = 10'h3FF;

        // Switches high through reset release
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        e = cyc + 1;
        push_ev(e + LAT, 10'h3FF, 10'h3FF, 10'h000);
        repeat (12) @(negedge Clock);

        // Asynchronous reset while outputs are high
        @(posedge Clock);
        #2 Reset = 1'b1;
        @(negedge Clock);
        Switches = 10'h000;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);

        // Glitch of three sampled cycles on bit 0
        Switches = 10'h001;
        repeat (3) @(negedge Clock);
        Switches = 10'h000;
        repeat (10) @(negedge Clock);

        // Long press and release on bit 8
        Switches = 10'h100;
        e = cyc + 1;
        push_ev(e + LAT, 10'h100, 10'h100, 10'h000);
        repeat (20) @(negedge Clock);
        Switches = 10'h000;
        e = cyc + 1;
        push_ev(e + LAT, 10'h000, 10'h000, 10'h100);
        repeat (10) @(negedge Clock);

        // Reset mid-count on bit 3 (counter at 2)
        Switches = 10'h008;
        repeat (4) @(posedge Clock);
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        e = cyc + 1;
        push_ev(e + LAT, 10'h008, 10'h008, 10'h000);
        repeat (10) @(negedge Clock);

        // Bits 1 and 9 rise together, bit 9 drops after two cycles
        Switches = 10'h20A;
        e = cyc + 1;
        push_ev(e + LAT, 10'h00A, 10'h002, 10'h000);
        repeat (2) @(negedge Clock);
        Switches = 10'h00A;
        repeat (10) @(negedge Clock);

        // Simultaneous release of bits 1 and 3
        Switches = 10'h000;
        e = cyc + 1;
        push_ev(e + LAT, 10'h000, 10'h000, 10'h00A);
        repeat (10) @(negedge Clock);

        done = 1'b1;
    end

endmodule
